// File: rtl/data_mem_unit.sv
// data_mem_unit: MEM-stage byte-addressed data memory with valid/ready requests,
// fixed-latency one-shot responses and exception reporting instead of faulting accesses.
module data_mem_unit #(
  parameter int ADDR_BITS = 13,
  parameter int LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        busy
);
  localparam int DEPTH = 2 ** ADDR_BITS;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t                 state_q;
  logic [3:0]             cnt_q;
  logic [31:0]            pend_rdata_q;
  logic [1:0]             pend_err_q;
  logic [7:0]             mem [DEPTH];
  logic [ADDR_BITS-1:0]   a;
  logic [ADDR_BITS-3:0]   wa;
  logic [31:0]            word_v, rdata_d;
  logic [15:0]            half_v;
  logic [7:0]             byte_v;
  logic [1:0]             err_d;
  logic                   accept;
  assign a         = req_addr[ADDR_BITS-1:0];
  assign wa        = a[ADDR_BITS-1:2];
  assign req_ready = state_q != WAIT;
  assign accept    = req_valid && req_ready;
  assign resp_valid = state_q == RESP;
  assign busy      = state_q == WAIT || (state_q == RESP && req_valid);
  // Loads read the whole aligned word, then pick the lane the address selects.
  assign word_v = {mem[{wa, 2'd3}], mem[{wa, 2'd2}], mem[{wa, 2'd1}], mem[{wa, 2'd0}]};
  assign half_v = a[1] ? word_v[31:16] : word_v[15:0];
  assign byte_v = word_v[{a[1:0], 3'b000} +: 8];
  assign err_d = req_size == 2'd3 ? 2'd3 :
                 (req_addr >> ADDR_BITS) != 32'd0 ? 2'd2 :
                 ((req_size == 2'd1 && req_addr[0]) ||
                  (req_size == 2'd2 && req_addr[1:0] != 2'd0)) ? 2'd1 : 2'd0;
  assign rdata_d = (req_write || err_d != 2'd0) ? 32'd0 :
                   req_size == 2'd0 ? {{24{req_sign & byte_v[7]}}, byte_v} :
                   req_size == 2'd1 ? {{16{req_sign & half_v[15]}}, half_v} : word_v;
  always_ff @(posedge clk) begin
    if (!rst && accept && req_write && err_d == 2'd0) begin
      mem[a] <= req_wdata[7:0];
      if (req_size != 2'd0) mem[{a[ADDR_BITS-1:1], 1'b1}] <= req_wdata[15:8];
      if (req_size == 2'd2) begin
        mem[{wa, 2'd2}] <= req_wdata[23:16];
        mem[{wa, 2'd3}] <= req_wdata[31:24];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      pend_rdata_q <= 32'd0;
      pend_err_q   <= 2'd0;
      resp_rdata   <= 32'd0;
      resp_err     <= 2'd0;
    end else if (accept) begin
      if (LATENCY == 0) begin
        state_q    <= RESP;
        resp_rdata <= rdata_d;
        resp_err   <= err_d;
      end else begin
        state_q      <= WAIT;
        cnt_q        <= 4'(LATENCY - 1);
        pend_rdata_q <= rdata_d;
        pend_err_q   <= err_d;
      end
    end else if (state_q == WAIT) begin
      if (cnt_q == 4'd0) begin
        state_q    <= RESP;
        resp_rdata <= pend_rdata_q;
        resp_err   <= pend_err_q;
      end else begin
        cnt_q <= cnt_q - 4'd1;
      end
    end else begin
      state_q <= IDLE;
    end
  end
endmodule

// File: tb/tb_data_mem_unit.sv
// tb_data_mem_unit: scoreboard bench driving a LATENCY=2 and a LATENCY=0 instance
// against a byte-array reference model.
module tb_data_mem_unit;
  typedef struct {logic [31:0] rd; logic [1:0] err; int due;} exp_t;
  logic        clk = 0, rst = 1;
  logic        rv [2], rw [2], rsg [2];
  logic [1:0]  rsz [2];
  logic [31:0] ra [2], rwd [2];
  logic        rr [2], vv [2], bsy [2];
  logic [31:0] rdat [2];
  logic [1:0]  rerr [2];
  logic [7:0]  mm [2][256];
  exp_t        q0 [$], q1 [$];
  int          lat [2] = '{2, 0};
  int          cyc = 0, ncmp = 0, nerr = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_unit #(.ADDR_BITS(13), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rr[0]), .req_write(rw[0]),
    .req_size(rsz[0]), .req_sign(rsg[0]), .req_addr(ra[0]), .req_wdata(rwd[0]),
    .resp_valid(vv[0]), .resp_rdata(rdat[0]), .resp_err(rerr[0]), .busy(bsy[0]));
  data_mem_unit #(.ADDR_BITS(13), .LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rr[1]), .req_write(rw[1]),
    .req_size(rsz[1]), .req_sign(rsg[1]), .req_addr(ra[1]), .req_wdata(rwd[1]),
    .resp_valid(vv[1]), .resp_rdata(rdat[1]), .resp_err(rerr[1]), .busy(bsy[1]));

  task automatic chk(string nm, int d, logic [31:0] got, logic [31:0] want);
    ncmp++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s dut%0d @cyc %0d: got %h want %h", nm, d, cyc, got, want);
    end
  endtask

  // Reference: size decides the byte count, alignment is addr modulo that count.
  task automatic model(int d, bit w, int sz, bit sg, logic [31:0] ad, logic [31:0] wd,
                       output logic [31:0] rd, output logic [1:0] err);
    int nb = 1 << sz;
    logic [31:0] v = 0;
    err = sz == 3 ? 2'd3 : ad >= 32'h2000 ? 2'd2 : (ad % nb) != 0 ? 2'd1 : 2'd0;
    rd = 0;
    if (err == 0) begin
      for (int i = 0; i < nb; i++)
        if (w) mm[d][ad[7:0] + i] = wd[8*i +: 8];
        else v = v | (32'(mm[d][ad[7:0] + i]) << (8 * i));
      if (!w && sg && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
      if (!w) rd = v;
    end
  endtask

  // Starts and ends at a falling edge so consecutive calls keep req_valid high.
  task automatic issue(int d, bit w, logic [1:0] sz, bit sg, logic [31:0] ad, logic [31:0] wd,
                       bit use_k = 0, logic [31:0] k_rd = 0, logic [1:0] k_err = 0);
    exp_t e;
    int n = 0;
    rv[d] = 1; rw[d] = w; rsz[d] = sz; rsg[d] = sg; ra[d] = ad; rwd[d] = wd;
    while (!rr[d]) begin
      if (++n > 20) begin
        ncmp++; nerr++;
        $display("FAIL ready_timeout dut%0d: got 0 want 1", d);
        rv[d] = 0;
        return;
      end
      @(negedge clk);
    end
    model(d, w, int'(sz), sg, ad, wd, e.rd, e.err);
    if (use_k) begin e.rd = k_rd; e.err = k_err; end
    e.due = cyc + 1 + lat[d];
    @(posedge clk);
    if (d == 1) q1.push_back(e); else q0.push_back(e);
    @(negedge clk);
    rv[d] = 0;
  endtask

  task automatic rand_op(int d);
    int r = $urandom_range(0, 19);
    int sz = $urandom_range(0, 15) == 0 ? 3 : $urandom_range(0, 2);
    logic [31:0] ad = $urandom_range(0, 255);
    if (r == 0) ad = 32'h2000 + $urandom_range(0, 255);
    else if (r == 1) ad = $urandom | 32'h8000_0000;
    else if (r < 14) ad = ad & ~32'((1 << sz) - 1);
    issue(d, 1'($urandom), 2'(sz), 1'($urandom), ad, $urandom);
    if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    int n;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) for (int d = 0; d < 2; d++) begin
        n = d == 1 ? q1.size() : q0.size();
        if (vv[d]) begin
          if (n == 0) begin
            ncmp++; nerr++;
            $display("FAIL unexpected_resp dut%0d @cyc %0d: got resp_valid 1 want 0", d, cyc);
          end else begin
            if (d == 1) e = q1.pop_front(); else e = q0.pop_front();
            chk("resp_rdata", d, rdat[d], e.rd);
            chk("resp_err", d, 32'(rerr[d]), 32'(e.err));
            chk("resp_cycle", d, cyc, e.due);
          end
        end
        chk("busy", d, 32'(bsy[d]), 32'(vv[d] ? rv[d] : n != 0));
        chk("req_ready", d, 32'(rr[d]), 32'(vv[d] || n == 0));
      end
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rv[d] = 0; rw[d] = 0; rsz[d] = 0; rsg[d] = 0; ra[d] = 0; rwd[d] = 0;
    end
    repeat (3) @(negedge clk);
    rst = 0;
    #2;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", d, 32'(rr[d]), 1);
      chk("rst_valid", d, 32'(vv[d]), 0);
      chk("rst_rdata", d, rdat[d], 0);
      chk("rst_err", d, 32'(rerr[d]), 0);
      chk("rst_busy", d, 32'(bsy[d]), 0);
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 256; a += 4) issue(d, 1, 2, 0, a, $urandom);
    issue(0, 1, 2, 0, 32'h10, 32'hDEADBEEF, 1, 0, 0);
    issue(0, 0, 0, 1, 32'h13, 0, 1, 32'hFFFFFFDE, 0);
    issue(0, 0, 1, 0, 32'h12, 0, 1, 32'h0000DEAD, 0);
    issue(0, 0, 2, 0, 32'h10, 0, 1, 32'hDEADBEEF, 0);
    issue(0, 1, 1, 0, 32'h11, 32'h1234, 1, 0, 1);
    issue(0, 0, 2, 0, 32'h10, 0, 1, 32'hDEADBEEF, 0);
    issue(0, 0, 2, 0, 32'h11, 0, 1, 0, 1);
    issue(0, 0, 3, 0, 32'h10, 0, 1, 0, 3);
    issue(0, 0, 0, 0, 32'h2000, 0, 1, 0, 2);
    issue(0, 1, 0, 0, 32'h20, 32'h5A, 1, 0, 0);
    rst = 1;
    q0.delete();
    @(negedge clk);
    rst = 0;
    #2;
    chk("midrst_ready", 0, 32'(rr[0]), 1);
    chk("midrst_valid", 0, 32'(vv[0]), 0);
    @(negedge clk);
    rst = 1; rv[0] = 1; rw[0] = 1; rsz[0] = 0; ra[0] = 32'h20; rwd[0] = 32'hAA;
    @(negedge clk);
    rst = 0; rv[0] = 0;
    issue(0, 0, 0, 0, 32'h20, 0, 1, 32'h0000005A, 0);
    repeat (150) rand_op(0);
    issue(1, 1, 2, 0, 32'h40, 32'h11223344, 1, 0, 0);
    issue(1, 0, 2, 0, 32'h40, 0, 1, 32'h11223344, 0);
    issue(1, 0, 0, 1, 32'h43, 0, 1, 32'h00000011, 0);
    issue(1, 0, 1, 1, 32'h40, 0, 1, 32'h00003344, 0);
    repeat (150) rand_op(1);
    repeat (8) @(negedge clk);
    chk("drain", 0, q0.size(), 0);
    chk("drain", 1, q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
